// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the ID-stage hazard/stall unit and the pipeline control.
// The pipeline (master) drives hazard sources; the unit (slave) returns strobes and debug state.
interface hazard_stall_unit_if #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_CNT      = 16
);
    // i_valid is a global step enable, not a handshake: with i_valid=0 every strobe is 0
    // and all state holds; with i_valid=1 the strobes take effect in this same cycle.
    logic                   i_valid;
    logic [NB_REG_ADDR-1:0] i_rs;
    logic [NB_REG_ADDR-1:0] i_rt;
    logic                   i_uses_rs;
    logic                   i_uses_rt;
    logic                   i_jump_rs;
    logic                   i_jump_taken;
    logic [NB_REG_ADDR-1:0] i_rd_ex;
    logic                   i_we_ex;
    logic                   i_mem_read_ex;
    logic [NB_REG_ADDR-1:0] i_rd_mem;
    logic                   i_mem_read_mem;
    logic                   o_stall_pc;
    logic                   o_stall_ifid;
    logic                   o_bubble_idex;
    logic                   o_flush_ifid;
    logic [1:0]             o_state;
    logic [NB_CNT-1:0]      o_stall_count;
    logic [NB_CNT-1:0]      o_flush_count;

    modport master (
        output i_valid, i_rs, i_rt, i_uses_rs, i_uses_rt, i_jump_rs, i_jump_taken,
               i_rd_ex, i_we_ex, i_mem_read_ex, i_rd_mem, i_mem_read_mem,
        input  o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_state,
               o_stall_count, o_flush_count
    );

    modport slave (
        input  i_valid, i_rs, i_rt, i_uses_rs, i_uses_rt, i_jump_rs, i_jump_taken,
               i_rd_ex, i_we_ex, i_mem_read_ex, i_rd_mem, i_mem_read_mem,
        output o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_state,
               o_stall_count, o_flush_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Resolves hazards that forwarding cannot: load-use and JR/JALR operand hazards.
// Stalls PC and IF/ID, bubbles ID/EX, flushes IF/ID on taken ID jumps; counts both.
module hazard_stall_unit #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_CNT      = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    hazard_stall_unit_if.slave bus
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1
    } state_t;

    state_t            r_state;
    logic [NB_CNT-1:0] r_stall_count;
    logic [NB_CNT-1:0] r_flush_count;

    logic w_lu;
    logic w_jr_ex;
    logic w_jr_mem;
    logic w_stall;
    logic w_active;
    logic w_stall_out;
    logic w_flush_out;

    // Matches on r0 are never hazards: r0 is hardwired zero.
    assign w_lu = bus.i_mem_read_ex && (bus.i_rd_ex != '0) &&
                  ((bus.i_uses_rs && (bus.i_rs == bus.i_rd_ex)) ||
                   (bus.i_uses_rt && (bus.i_rt == bus.i_rd_ex)));
    assign w_jr_ex  = bus.i_jump_rs && bus.i_we_ex && (bus.i_rd_ex != '0) &&
                      (bus.i_rs == bus.i_rd_ex);
    assign w_jr_mem = bus.i_jump_rs && bus.i_mem_read_mem && (bus.i_rd_mem != '0) &&
                      (bus.i_rs == bus.i_rd_mem);

    assign w_stall     = (r_state == HOLD) || w_lu || w_jr_ex || w_jr_mem;
    assign w_active    = bus.i_valid && !i_reset;
    assign w_stall_out = w_stall && w_active;
    // A jump whose rs is still pending must not redirect, so stall masks flush.
    assign w_flush_out = bus.i_jump_taken && !w_stall && w_active;

    assign bus.o_stall_pc    = w_stall_out;
    assign bus.o_stall_ifid  = w_stall_out;
    assign bus.o_bubble_idex = w_stall_out;
    assign bus.o_flush_ifid  = w_flush_out;
    assign bus.o_state       = r_state;
    assign bus.o_stall_count = r_stall_count;
    assign bus.o_flush_count = r_flush_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= RUN;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (bus.i_valid) begin
            case (r_state)
                // A load feeding JR needs a second bubble: the load result only
                // exists after MEM, one stage later than an ALU result.
                RUN:     if (w_jr_ex && bus.i_mem_read_ex) r_state <= HOLD;
                HOLD:    r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (w_stall_out && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_flush_out && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end
endmodule
